// File: rtl/audio_i2s_tx.sv
// I2S slave-mode DAC serializer: stereo FIFO fed by tick, words shifted out MSB first
// on the codec's BCLK/LRCK, which are sampled as asynchronous inputs on CLOCK_50.
`timescale 1ns/1ps
module audio_i2s_tx #(
  parameter int WIDTH       = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          tick,
  input  logic [WIDTH-1:0]              in_L,
  input  logic [WIDTH-1:0]              in_R,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic                          sample_req,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH);

  // Bit 0 carries BCLK, bit 1 carries LRCK through the same synchronizer chain.
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0] hist_q;
  logic [1:0] cur;
  logic       bclk_fall, lr_fall, lr_rise;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= {AUD_DACLRCK, AUD_BCLK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur       = sync_q[SYNC_STAGES-1];
  assign bclk_fall = hist_q[0] & ~cur[0];
  assign lr_fall   = hist_q[1] & ~cur[1];
  assign lr_rise   = ~hist_q[1] & cur[1];

  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      count_reg;
  logic               empty, full, pop_en, wr_en, overflow_reg;
  logic [2*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]   pop_l, pop_r;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == LW'(FIFO_DEPTH));
  assign pop_en  = lr_fall & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_en   = tick & (~full | pop_en);
  assign rd_data = mem[rd_ptr];
  assign pop_l   = pop_en ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign pop_r   = pop_en ? rd_data[WIDTH-1:0]       : '0;

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr] <= {in_L, in_R};
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      count_reg    <= count_reg + LW'(wr_en) - LW'(pop_en);
      overflow_reg <= tick & ~wr_en;
    end
  end

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, PAD} state_t;
  state_t state, state_next;
  logic   load_l, load_r, shift_en, clear_dat;
  logic [WIDTH-1:0] shift_reg, hold_r;
  logic [CW-1:0]    bit_cnt;
  logic             dat_reg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_l     = 1'b0;
    load_r     = 1'b0;
    shift_en   = 1'b0;
    clear_dat  = 1'b0;
    if (lr_fall) begin
      state_next = ARM;
      load_l     = 1'b1;
    end else if (lr_rise && state != IDLE) begin
      state_next = ARM;
      load_r     = 1'b1;
    end else if (bclk_fall) begin
      case (state)
        ARM: begin
          shift_en   = 1'b1;
          state_next = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt != '0) shift_en = 1'b1;
          else begin
            clear_dat  = 1'b1;
            state_next = PAD;
          end
        end
        default: ;
      endcase
    end
  end

  // The left word goes straight from the FIFO head into the shifter; only R needs holding.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      hold_r    <= '0;
      bit_cnt   <= '0;
      dat_reg   <= 1'b0;
    end else if (load_l) begin
      shift_reg <= pop_l;
      hold_r    <= pop_r;
      dat_reg   <= 1'b0;
    end else if (load_r) begin
      shift_reg <= hold_r;
      dat_reg   <= 1'b0;
    end else if (shift_en) begin
      dat_reg   <= shift_reg[WIDTH-1];
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      bit_cnt   <= (state == ARM) ? CW'(WIDTH-1) : bit_cnt - CW'(1);
    end else if (clear_dat) begin
      dat_reg   <= 1'b0;
    end
  end

  assign AUD_DACDAT = dat_reg;
  assign sample_req = lr_fall;
  assign underflow  = lr_fall & empty;
  assign overflow   = overflow_reg;
  assign fifo_full  = full;
  assign fifo_level = count_reg;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized scoreboard bench for audio_i2s_tx: a queue-level FIFO model predicts each
// serialized word, and a BCLK-rise monitor deserializes the pin and compares.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int H     = 8;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n = 1'b0;
  logic              tick = 1'b0;
  logic [WIDTH-1:0]  in_L = '0;
  logic [WIDTH-1:0]  in_R = '0;
  logic              AUD_BCLK = 1'b0;
  logic              AUD_DACLRCK = 1'b1;
  logic              AUD_DACDAT, sample_req, fifo_full, overflow, underflow;
  logic [2:0]        fifo_level;

  audio_i2s_tx #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .tick(tick), .in_L(in_L), .in_R(in_R),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .sample_req(sample_req), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .overflow(overflow), .underflow(underflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;
  logic [63:0] model_q[$];
  logic [31:0] exp_q[$];
  int exp_req = 0, exp_uf = 0, req_seen = 0, uf_seen = 0;
  int slots = 36;
  bit mon_en = 0;
  bit gen_done = 0;
  int s_tab[4] = '{36, 40, 32, 16};

  logic        prev_lr = 1'b1;
  logic        cur_ch = 1'b0;
  int          idx = 0;
  int          word_n = 0;
  bit          in_word = 0;
  logic [63:0] got_bits = '0;
  bit          found, loud;
  int          nwait;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic finish_word();
    logic [31:0] w;
    logic [63:0] want;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL word_%0d got=%h want=<no expected word>", word_n, got_bits);
    end else begin
      w = exp_q.pop_front();
      want = '0;
      for (int j = 0; j < slots - 1; j++)
        want = {want[62:0], (j < WIDTH) ? w[WIDTH-1-j] : 1'b0};
      $display("word %0d ch=%s slots=%0d want=%h got=%h", word_n, cur_ch ? "R" : "L",
               slots, want, got_bits);
      check($sformatf("word_%0d", word_n), got_bits, want);
    end
    word_n++;
  endtask

  // Model: a stereo pair goes in if there is room, otherwise the tick is dropped.
  task automatic issue_tick(input logic [31:0] l, input logic [31:0] r);
    bit drop;
    drop = (model_q.size() == DEPTH);
    if (!drop) model_q.push_back({l, r});
    in_L = l;
    in_R = r;
    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    $display("tick L=%h R=%h drop=%0d level=%0d", l, r, drop, fifo_level);
    check("overflow", 64'(overflow), 64'(drop));
    check("fifo_level", 64'(fifo_level), 64'(model_q.size()));
    check("fifo_full", 64'(fifo_full), 64'(model_q.size() == DEPTH));
  endtask

  // Model: each left-frame start takes the oldest pair, or silence when empty.
  task automatic frame_start();
    logic [63:0] p;
    exp_req++;
    if (model_q.size() > 0) p = model_q.pop_front();
    else begin
      p = '0;
      exp_uf++;
    end
    if (mon_en) begin
      exp_q.push_back(p[63:32]);
      exp_q.push_back(p[31:0]);
    end
  endtask

  task automatic bclk_cycles(input int n);
    repeat (n) begin
      repeat (H) @(negedge CLOCK_50);
      AUD_BCLK = 1'b1;
      repeat (H) @(negedge CLOCK_50);
      AUD_BCLK = 1'b0;
    end
  endtask

  task automatic run_frames(input int n, input int s);
    slots = s;
    @(negedge CLOCK_50);
    for (int f = 0; f < n; f++) begin
      AUD_DACLRCK = 1'b0;
      frame_start();
      bclk_cycles(s);
      AUD_DACLRCK = 1'b1;
      bclk_cycles(s);
    end
    repeat (4) @(negedge CLOCK_50);
    check("sample_req_count", 64'(req_seen), 64'(exp_req));
    check("underflow_count", 64'(uf_seen), 64'(exp_uf));
  endtask

  task automatic sim_tick(input logic [31:0] l, input logic [31:0] r);
    bit seen;
    seen = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge CLOCK_50);
      if (sample_req === 1'b1) seen = 1;
    end
    check("sample_req_for_sim_tick", 64'(seen), 64'(1));
    if (seen) issue_tick(l, r);
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLOCK_50);
        if (reset_n) begin
          if (sample_req === 1'b1) req_seen++;
          if (underflow === 1'b1) uf_seen++;
        end
      end
      forever begin
        @(posedge AUD_BCLK);
        if (!mon_en) begin
          prev_lr = 1'b1;
          in_word = 0;
        end else begin
          if (AUD_DACLRCK != prev_lr) begin
            in_word  = 1;
            idx      = 1;
            got_bits = '0;
            cur_ch   = AUD_DACLRCK;
          end else begin
            idx++;
            got_bits = {got_bits[62:0], AUD_DACDAT};
          end
          prev_lr = AUD_DACLRCK;
          if (in_word && idx == slots) begin
            finish_word();
            in_word = 0;
          end
        end
      end
    join_none

    repeat (5) @(negedge CLOCK_50);
    check("rst_dacdat", 64'(AUD_DACDAT), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_full", 64'(fifo_full), 64'(0));
    check("rst_sample_req", 64'(sample_req), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));
    reset_n = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    check("idle_ignores_rise", 64'(AUD_DACDAT), 64'(0));
    mon_en = 1;

    // Basic frame, then a 64-BCLK frame that drops the LSB, then empty frames.
    issue_tick(32'hA5A5_0001, 32'h8000_0000);
    run_frames(1, 36);
    issue_tick(32'hA5A5_0001, 32'h8000_0001);
    run_frames(1, 32);
    run_frames(2, 36);

    // Overflow: five ticks into a four-deep FIFO, then drain in order.
    repeat (5) issue_tick($urandom, $urandom);
    run_frames(4, 36);

    for (int it = 0; it < 5; it++) begin
      int nt;
      nt = int'($urandom_range(0, 5));
      repeat (nt) issue_tick($urandom, $urandom);
      run_frames(int'($urandom_range(1, 3)), s_tab[int'($urandom_range(0, 3))]);
    end
    if (model_q.size() > 0) run_frames(model_q.size(), 36);

    // Tick coinciding with frame start: empty, then full.
    fork
      run_frames(2, 36);
      sim_tick($urandom, $urandom);
    join
    repeat (4) issue_tick($urandom, $urandom);
    fork
      run_frames(1, 36);
      sim_tick($urandom, $urandom);
    join
    run_frames(4, 36);

    // Reset in the middle of a word.
    mon_en = 0;
    issue_tick(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue_tick($urandom, $urandom);
    gen_done = 0;
    fork
      begin
        run_frames(1, 36);
        gen_done = 1;
      end
      begin
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
          @(negedge CLOCK_50);
          if (AUD_DACDAT === 1'b1) found = 1;
        end
        check("dacdat_high_before_reset", 64'(found), 64'(1));
        #3 reset_n = 1'b0;
        model_q.delete();
        #1;
        check("midword_rst_dacdat", 64'(AUD_DACDAT), 64'(0));
        check("midword_rst_level", 64'(fifo_level), 64'(0));
        check("midword_rst_full", 64'(fifo_full), 64'(0));
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        loud = 0;
        nwait = 0;
        while (!gen_done && nwait < 5000) begin
          @(negedge CLOCK_50);
          nwait++;
          if (AUD_DACDAT !== 1'b0) loud = 1;
        end
        check("silent_until_lr_fall", 64'(loud), 64'(0));
      end
    join

    mon_en = 1;
    @(negedge CLOCK_50);
    issue_tick($urandom, $urandom);
    run_frames(1, 36);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
